// File: rtl/amstrad_crtc_pkg.sv
// Shared definitions for the UM6845R (type 1) CRTC model: register indices,
// reset values, write masks and the vertical frame state.
package amstrad_crtc_pkg;

    localparam int unsigned NUM_REGS = 16;

    localparam logic [4:0] R_HTOTAL  = 5'd0;
    localparam logic [4:0] R_HDISP   = 5'd1;
    localparam logic [4:0] R_HSPOS   = 5'd2;
    localparam logic [4:0] R_SYNCW   = 5'd3;
    localparam logic [4:0] R_VTOTAL  = 5'd4;
    localparam logic [4:0] R_VADJ    = 5'd5;
    localparam logic [4:0] R_VDISP   = 5'd6;
    localparam logic [4:0] R_VSPOS   = 5'd7;
    localparam logic [4:0] R_ILACE   = 5'd8;
    localparam logic [4:0] R_MAXRAS  = 5'd9;
    localparam logic [4:0] R_CSTART  = 5'd10;
    localparam logic [4:0] R_CEND    = 5'd11;
    localparam logic [4:0] R_SADDR_H = 5'd12;
    localparam logic [4:0] R_SADDR_L = 5'd13;
    localparam logic [4:0] R_CURS_H  = 5'd14;
    localparam logic [4:0] R_CURS_L  = 5'd15;
    localparam logic [4:0] R_LPEN_H  = 5'd16;
    localparam logic [4:0] R_LPEN_L  = 5'd17;
    localparam logic [4:0] R_ALL_ONE = 5'd31;

    typedef logic [NUM_REGS-1:0][7:0] reg_file_t;

    // Listed from R15 down to R0.
    localparam reg_file_t REG_RESET = {
        8'h00, 8'h00, 8'h00, 8'h30,
        8'h00, 8'h00, 8'h07, 8'h00,
        8'd30, 8'd25, 8'd0,  8'd38,
        8'h8E, 8'd46, 8'd40, 8'd63
    };

    // Implemented bits per register, R15 down to R0.
    localparam reg_file_t REG_MASK = {
        8'hFF, 8'h3F, 8'hFF, 8'h3F,
        8'h1F, 8'h7F, 8'h1F, 8'h03,
        8'h7F, 8'h7F, 8'h1F, 8'h7F,
        8'hFF, 8'hFF, 8'hFF, 8'hFF
    };

    typedef enum logic {S_ROWS, S_ADJUST} frame_state_t;

    // Frame start address {R12[5:0], R13}.
    function automatic logic [13:0] start_addr(input reg_file_t r);
        return {r[R_SADDR_H[3:0]][5:0], r[R_SADDR_L[3:0]]};
    endfunction

endpackage

// File: rtl/amstrad_crtc_regs.sv
// CPU-facing register file: address register, masked register storage and
// the registered read-back mux.
module amstrad_crtc_regs
    import amstrad_crtc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_en,
    input  logic       rs,
    input  logic       r_nw,
    input  logic [7:0] di,
    input  logic       vblank,
    output logic [7:0] rdata,
    output reg_file_t  regs
);

    logic [4:0] ar_q;
    reg_file_t  regs_q;
    logic [7:0] rdata_q;
    logic [7:0] rd_mux;

    // Read value for the current access: status on RS=0, sparse data otherwise.
    always_comb begin
        rd_mux = 8'h00;
        if (!rs) begin
            rd_mux = {2'b00, vblank, 5'b00000};
        end else begin
            case (ar_q)
                R_CURS_H:  rd_mux = regs_q[R_CURS_H[3:0]];
                R_CURS_L:  rd_mux = regs_q[R_CURS_L[3:0]];
                R_ALL_ONE: rd_mux = 8'hFF;
                default:   rd_mux = 8'h00;
            endcase
        end
    end

    // CPU strobe handling; registers above R15 do not exist and drop writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q    <= 5'd0;
            regs_q  <= REG_RESET;
            rdata_q <= 8'h00;
        end else if (cpu_en) begin
            if (r_nw) begin
                rdata_q <= rd_mux;
            end else if (!rs) begin
                ar_q <= di[4:0];
            end else if (!ar_q[4]) begin
                regs_q[ar_q[3:0]] <= di & REG_MASK[ar_q[3:0]];
            end
        end
    end

    assign rdata = rdata_q;
    assign regs  = regs_q;

endmodule

// File: rtl/amstrad_crtc.sv
// UM6845R (type 1) CRTC: character/raster counters, MA/RA generation and
// HSYNC/VSYNC/DE for the CPC gate array. Outputs describe the character
// that was current on the CE that registered them.
module amstrad_crtc
    import amstrad_crtc_pkg::*;
#(
    parameter int unsigned VSYNC_LINES = 16,
    parameter int unsigned MA_W        = 14
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            CE,
    input  logic            CPU_EN,
    input  logic            RS,
    input  logic            R_NW,
    input  logic [7:0]      DI,
    output logic [7:0]      DO,
    output logic            HSYNC,
    output logic            VSYNC,
    output logic            DE,
    output logic [MA_W-1:0] MA,
    output logic [4:0]      RA
);

    localparam int unsigned VS_W = $clog2(VSYNC_LINES + 1);

    reg_file_t crtc_regs;
    logic      vblank;

    amstrad_crtc_regs u_regs (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .cpu_en (CPU_EN),
        .rs     (RS),
        .r_nw   (R_NW),
        .di     (DI),
        .vblank (vblank),
        .rdata  (DO),
        .regs   (crtc_regs)
    );

    logic [7:0] r_htotal, r_hdisp, r_hspos, r_syncw, r_vtotal, r_vadj;
    logic [7:0] r_vdisp, r_vspos, r_maxras;

    assign r_htotal = crtc_regs[R_HTOTAL[3:0]];
    assign r_hdisp  = crtc_regs[R_HDISP[3:0]];
    assign r_hspos  = crtc_regs[R_HSPOS[3:0]];
    assign r_syncw  = crtc_regs[R_SYNCW[3:0]];
    assign r_vtotal = crtc_regs[R_VTOTAL[3:0]];
    assign r_vadj   = crtc_regs[R_VADJ[3:0]];
    assign r_vdisp  = crtc_regs[R_VDISP[3:0]];
    assign r_vspos  = crtc_regs[R_VSPOS[3:0]];
    assign r_maxras = crtc_regs[R_MAXRAS[3:0]];

    // Bits the timing logic never looks at (type 1 ignores R3[7:4], no cursor).
    logic unused_regs;
    assign unused_regs = ^{r_syncw[7:4], r_vtotal[7], r_vadj[7:5], r_vdisp[7], r_vspos[7],
                           r_maxras[7:5], crtc_regs[R_SADDR_H[3:0]][7:6],
                           crtc_regs[R_ILACE[3:0]], crtc_regs[R_CSTART[3:0]],
                           crtc_regs[R_CEND[3:0]], crtc_regs[R_CURS_H[3:0]],
                           crtc_regs[R_CURS_L[3:0]]};

    logic [7:0]      hcc_q, hcc_d;
    logic [6:0]      vcc_q, vcc_d;
    logic [4:0]      vlc_q, vlc_d;
    logic [4:0]      vtac_q, vtac_d;
    frame_state_t    state_q, state_d;
    logic [MA_W-1:0] ma_row_q, ma_row_d;
    logic [3:0]      hs_rem_q, hs_rem_d;
    logic [VS_W-1:0] vs_rem_q, vs_rem_d, vs_dec;

    logic            line_end, new_frame;
    logic            hs_now, vs_now, de_now;
    logic [MA_W-1:0] ma_now, frame_start;
    logic [4:0]      ra_now;

    logic            hsync_q, vsync_q, de_q;
    logic [MA_W-1:0] ma_q;
    logic [4:0]      ra_q;

    assign frame_start = MA_W'(start_addr(crtc_regs));
    assign line_end    = (hcc_q == r_htotal);
    assign vblank      = !((state_q == S_ROWS) && (vcc_q < r_vdisp[6:0]));

    // Horizontal, raster and row counters plus the rows/adjust frame state.
    always_comb begin
        hcc_d     = line_end ? 8'd0 : hcc_q + 8'd1;
        vcc_d     = vcc_q;
        vlc_d     = vlc_q;
        vtac_d    = vtac_q;
        state_d   = state_q;
        ma_row_d  = ma_row_q;
        new_frame = 1'b0;
        if (line_end) begin
            unique case (state_q)
                S_ROWS: begin
                    if (vlc_q == r_maxras[4:0]) begin
                        vlc_d    = 5'd0;
                        vcc_d    = vcc_q + 7'd1;
                        ma_row_d = ma_row_q + MA_W'(r_hdisp);
                        if (vcc_q == r_vtotal[6:0]) begin
                            if (r_vadj[4:0] != 5'd0) begin
                                state_d = S_ADJUST;
                                vtac_d  = 5'd0;
                            end else begin
                                new_frame = 1'b1;
                            end
                        end
                    end else begin
                        vlc_d = vlc_q + 5'd1;
                    end
                end
                S_ADJUST: begin
                    // >= rather than == so a mid-adjust R5 decrease cannot run away.
                    if (({1'b0, vtac_q} + 6'd1) >= {1'b0, r_vadj[4:0]}) begin
                        new_frame = 1'b1;
                    end else begin
                        vtac_d = vtac_q + 5'd1;
                    end
                end
                default: ;
            endcase
            if (new_frame) begin
                vcc_d    = 7'd0;
                vlc_d    = 5'd0;
                vtac_d   = 5'd0;
                state_d  = S_ROWS;
                ma_row_d = frame_start;
            end
        end
    end

    // Output values for the current character and the sync width counters.
    always_comb begin
        hs_rem_d = hs_rem_q;
        hs_now   = 1'b0;
        if (hs_rem_q != 4'd0) begin
            hs_now   = 1'b1;
            hs_rem_d = hs_rem_q - 4'd1;
        end else if ((hcc_q == r_hspos) && (r_syncw[3:0] != 4'd0)) begin
            hs_now   = 1'b1;
            hs_rem_d = r_syncw[3:0] - 4'd1;
        end

        // vs_rem counts lines still to run, including the current one.
        vs_dec   = (vs_rem_q != '0) ? vs_rem_q - VS_W'(1) : '0;
        vs_rem_d = vs_rem_q;
        if (hcc_q == 8'd0) begin
            vs_rem_d = vs_dec;
            if ((vs_dec == '0) && (vcc_q == r_vspos[6:0]) && (vlc_q == 5'd0)) begin
                vs_rem_d = VS_W'(VSYNC_LINES);
            end
        end
        vs_now = (vs_rem_d != '0);

        de_now = (hcc_q < r_hdisp) && (vcc_q < r_vdisp[6:0]) && (state_q == S_ROWS);
        ma_now = ma_row_q + MA_W'(hcc_q);
        ra_now = (state_q == S_ROWS) ? vlc_q : vtac_q;
    end

    // State and output registers, advanced only on the character clock.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hcc_q    <= 8'd0;
            vcc_q    <= 7'd0;
            vlc_q    <= 5'd0;
            vtac_q   <= 5'd0;
            state_q  <= S_ROWS;
            ma_row_q <= MA_W'(start_addr(REG_RESET));
            hs_rem_q <= 4'd0;
            vs_rem_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            de_q     <= 1'b0;
            ma_q     <= MA_W'(start_addr(REG_RESET));
            ra_q     <= 5'd0;
        end else if (CE) begin
            hcc_q    <= hcc_d;
            vcc_q    <= vcc_d;
            vlc_q    <= vlc_d;
            vtac_q   <= vtac_d;
            state_q  <= state_d;
            ma_row_q <= ma_row_d;
            hs_rem_q <= hs_rem_d;
            vs_rem_q <= vs_rem_d;
            hsync_q  <= hs_now;
            vsync_q  <= vs_now;
            de_q     <= de_now;
            ma_q     <= ma_now;
            ra_q     <= ra_now;
        end
    end

    assign HSYNC = hsync_q;
    assign VSYNC = vsync_q;
    assign DE    = de_q;
    assign MA    = ma_q;
    assign RA    = ra_q;

endmodule

// File: tb/tb_amstrad_crtc.sv
// Self-checking bench for amstrad_crtc: register access table plus directed
// timing sequences with hand-computed expectations.
module tb_amstrad_crtc;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CE = 1'b0;
    logic        CPU_EN = 1'b0;
    logic        RS = 1'b0;
    logic        R_NW = 1'b0;
    logic [7:0]  DI = 8'h00;
    logic [7:0]  DO;
    logic        HSYNC, VSYNC, DE;
    logic [13:0] MA;
    logic [4:0]  RA;

    amstrad_crtc #(
        .VSYNC_LINES (16),
        .MA_W        (14)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .CE      (CE),
        .CPU_EN  (CPU_EN),
        .RS      (RS),
        .R_NW    (R_NW),
        .DI      (DI),
        .DO      (DO),
        .HSYNC   (HSYNC),
        .VSYNC   (VSYNC),
        .DE      (DE),
        .MA      (MA),
        .RA      (RA)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int gap = 0;

    typedef struct {
        logic       rs;
        logic       rnw;
        logic [7:0] di;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rs, input logic rnw, input logic [7:0] di,
                       input logic [7:0] exp, input string name);
        vec_t v;
        v.rs = rs; v.rnw = rnw; v.di = di; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // One character clock; outputs are stable on return.
    task automatic step();
        if (gap != 0) begin
            repeat (gap) @(posedge CLK);
            #1;
        end
        CE = 1'b1;
        @(posedge CLK);
        #1;
        CE = 1'b0;
    endtask

    task automatic cpu(input logic rs, input logic rnw, input logic [7:0] d,
                       output logic [7:0] q);
        RS = rs; R_NW = rnw; DI = d; CPU_EN = 1'b1;
        @(posedge CLK);
        #1;
        CPU_EN = 1'b0;
        q = DO;
    endtask

    task automatic wreg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] q;
        cpu(1'b0, 1'b0, a, q);
        cpu(1'b1, 1'b0, d, q);
    endtask

    task automatic do_reset();
        CE = 1'b0;
        RESET_N = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q;
        int r1, r2, hs_r1, hs_hi, vs_hi, de_hi, de_adj;
        logic prev_hs, prev_vs;

        // Reset state
        #12;
        chk("rst_hsync", HSYNC, 0);
        chk("rst_vsync", VSYNC, 0);
        chk("rst_de", DE, 0);
        chk("rst_ma", MA, 14'h3000);
        chk("rst_ra", RA, 0);
        chk("rst_do", DO, 0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // Register access table
        add(0, 0, 8'd14, 8'h00, "");
        add(1, 0, 8'h3F, 8'h00, "");
        add(1, 1, 8'h00, 8'h3F, "r14_read");
        add(1, 0, 8'hFF, 8'h00, "");
        add(1, 1, 8'h00, 8'h3F, "r14_mask");
        add(0, 0, 8'd12, 8'h00, "");
        add(1, 1, 8'h00, 8'h00, "r12_read_zero");
        add(0, 0, 8'd31, 8'h00, "");
        add(1, 1, 8'h00, 8'hFF, "r31_read");
        add(0, 0, 8'hEF, 8'h00, "");
        add(1, 0, 8'hA5, 8'h00, "");
        add(1, 1, 8'h00, 8'hA5, "ar_5bit_r15");
        add(0, 0, 8'd16, 8'h00, "");
        add(1, 1, 8'h00, 8'h00, "r16_lpen");
        add(0, 0, 8'd17, 8'h00, "");
        add(1, 0, 8'h77, 8'h00, "");
        add(1, 1, 8'h00, 8'h00, "r17_lpen");
        add(0, 0, 8'd0, 8'h00, "");
        add(1, 1, 8'h00, 8'h00, "r0_read_zero");
        add(0, 1, 8'h00, 8'h00, "status_display");
        for (int i = 0; i < vecs.size(); i++) begin
            cpu(vecs[i].rs, vecs[i].rnw, vecs[i].di, q);
            if (vecs[i].rnw) chk(vecs[i].name, q, vecs[i].exp);
        end

        // Default horizontal timing, CE every 16 CLK
        gap = 15; r1 = 0; r2 = 0; hs_hi = 0; de_hi = 0; prev_hs = 1'b0;
        for (int n = 1; n <= 130; n++) begin
            step();
            if (HSYNC && !prev_hs) begin
                if (r1 == 0) r1 = n; else if (r2 == 0) r2 = n;
            end
            prev_hs = HSYNC;
            if (n <= 64) begin
                hs_hi += HSYNC ? 1 : 0;
                de_hi += DE ? 1 : 0;
            end
            if (n == 1) begin
                chk("ma_hcc0", MA, 14'h3000);
                chk("de_hcc0", DE, 1);
            end
            if (n == 40) chk("ma_hcc39", MA, 14'h3027);
            if (n == 41) chk("de_hcc40", DE, 0);
        end
        chk("hs_first_rise", r1, 47);
        chk("hs_period", r2 - r1, 64);
        chk("hs_width", hs_hi, 14);
        chk("de_per_line", de_hi, 40);

        // Mid-frame reset at line 100 with R2 moved so HSYNC overlaps DE
        do_reset();
        wreg(8'd2, 8'd10);
        gap = 0;
        for (int n = 1; n <= 6416; n++) step();
        chk("l100_hsync", HSYNC, 1);
        chk("l100_de", DE, 1);
        chk("l100_ra", RA, 4);
        chk("l100_ma", MA, 14'h31EF);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_hsync", HSYNC, 0);
        chk("async_de", DE, 0);
        chk("async_ma", MA, 14'h3000);
        chk("async_ra", RA, 0);
        @(posedge CLK);
        #2;
        RESET_N = 1'b1;
        wreg(8'd14, 8'h00);
        cpu(1'b0, 1'b0, 8'd14, q);
        cpu(1'b1, 1'b1, 8'h00, q);
        chk("r14_after_reset", q, 8'h00);

        // Full default frame
        r1 = 0; r2 = 0; hs_r1 = 0; vs_hi = 0; de_hi = 0; prev_hs = 1'b0; prev_vs = 1'b0;
        for (int n = 1; n <= 35400; n++) begin
            step();
            if (n == 1) begin
                chk("frame_ma0", MA, 14'h3000);
                chk("frame_de0", DE, 1);
            end
            if (HSYNC && !prev_hs && hs_r1 == 0) hs_r1 = n;
            prev_hs = HSYNC;
            if (VSYNC && !prev_vs) begin
                if (r1 == 0) r1 = n; else if (r2 == 0) r2 = n;
            end
            prev_vs = VSYNC;
            if (n <= 19968) begin
                vs_hi += VSYNC ? 1 : 0;
                de_hi += DE ? 1 : 0;
            end
            if (n == 1537) begin
                cpu(1'b0, 1'b1, 8'h00, q);
                chk("status_line24", q, 8'h00);
            end
            if (n == 16001) begin
                cpu(1'b0, 1'b1, 8'h00, q);
                chk("status_line250", q, 8'h20);
            end
        end
        chk("hs_rise_after_reset", hs_r1, 47);
        chk("vs_rise_line240", r1, 15361);
        chk("frame_312_lines", r2 - r1, 19968);
        chk("vs_width_16_lines", vs_hi, 1024);
        chk("de_per_frame", de_hi, 8000);

        // Vertical adjust: R4=3, R5=3 gives 35-line frames
        do_reset();
        wreg(8'd4, 8'd3);
        wreg(8'd5, 8'd3);
        wreg(8'd7, 8'd1);
        r1 = 0; r2 = 0; de_hi = 0; de_adj = 0; prev_vs = 1'b0;
        for (int n = 1; n <= 2817; n++) begin
            step();
            if (VSYNC && !prev_vs) begin
                if (r1 == 0) r1 = n; else if (r2 == 0) r2 = n;
            end
            prev_vs = VSYNC;
            if (n <= 2240) de_hi += DE ? 1 : 0;
            if (n >= 2049 && n <= 2240) de_adj += DE ? 1 : 0;
            if (n == 1985) chk("adj_ra_pre", RA, 7);
            if (n == 2049) chk("adj_ra0", RA, 0);
            if (n == 2113) chk("adj_ra1", RA, 1);
            if (n == 2177) chk("adj_ra2", RA, 2);
            if (n == 2100) begin
                cpu(1'b0, 1'b1, 8'h00, q);
                chk("adj_status", q, 8'h20);
            end
            if (n == 2241) begin
                chk("adj_newframe_ra", RA, 0);
                chk("adj_newframe_ma", MA, 14'h3000);
            end
        end
        chk("adj_vs_rise", r1, 513);
        chk("adj_frame_35_lines", r2 - r1, 2240);
        chk("adj_de_zero", de_adj, 0);
        chk("adj_de_frame", de_hi, 1280);

        // Start address R12/R13 and MA wrap
        do_reset();
        wreg(8'd4, 8'd3);
        wreg(8'd12, 8'h10);
        wreg(8'd13, 8'h00);
        for (int n = 1; n <= 4098; n++) begin
            step();
            if (n == 2048) chk("ma_end_frame1", MA, 14'h30B7);
            if (n == 2049) begin
                chk("ma_frame2_start", MA, 14'h1000);
                chk("de_frame2_start", DE, 1);
            end
            if (n == 2561) begin
                chk("ma_row1", MA, 14'h1028);
                chk("ra_row1", RA, 0);
                wreg(8'd12, 8'h3F);
                wreg(8'd13, 8'hFF);
            end
            if (n == 4097) chk("ma_3fff", MA, 14'h3FFF);
            if (n == 4098) chk("ma_wrap", MA, 14'h0000);
        end

        // R3 = 0x80: no HSYNC, VSYNC width unchanged
        do_reset();
        wreg(8'd3, 8'h80);
        wreg(8'd4, 8'd3);
        wreg(8'd7, 8'd1);
        r1 = 0; hs_hi = 0; vs_hi = 0; prev_vs = 1'b0;
        for (int n = 1; n <= 4096; n++) begin
            step();
            hs_hi += HSYNC ? 1 : 0;
            if (n <= 2048) vs_hi += VSYNC ? 1 : 0;
            if (VSYNC && !prev_vs && r1 == 0) r1 = n;
            prev_vs = VSYNC;
        end
        chk("r3_zero_no_hsync", hs_hi, 0);
        chk("r3_vs_rise", r1, 513);
        chk("r3_vs_width", vs_hi, 1024);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
